// File: rtl/store_aligner_pkg.sv
// Shared definitions for the P7 memory-stage store path.
// Store-type codes, memory-map constants and the AdES exception code.
package store_aligner_pkg;

  localparam logic [1:0] ST_W   = 2'b00;
  localparam logic [1:0] ST_H   = 2'b01;
  localparam logic [1:0] ST_B   = 2'b10;
  localparam logic [1:0] ST_NOP = 2'b11;

  localparam logic [31:0] DM_END   = 32'h0000_2FFF;
  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] IG_BASE  = 32'h0000_7F20;
  localparam logic [31:0] TC_WIN   = 32'd12;
  localparam logic [31:0] IG_WIN   = 32'd4;
  localparam logic [31:0] TC_COUNT = 32'd8;

  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/store_addr_check.sv
// Combinational store legality check against the P7 memory map.
// Flags misalignment, unmapped targets, sub-word device stores and timer COUNT writes.
module store_addr_check
  import store_aligner_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  st_type,
  output logic        ades
);

  logic in_dm, in_tc0, in_tc1, in_ig, in_dev, misalign, count_wr;

  assign in_dm  = (addr <= DM_END);
  assign in_tc0 = (addr >= TC0_BASE) && (addr < TC0_BASE + TC_WIN);
  assign in_tc1 = (addr >= TC1_BASE) && (addr < TC1_BASE + TC_WIN);
  assign in_ig  = (addr >= IG_BASE)  && (addr < IG_BASE + IG_WIN);
  assign in_dev = in_tc0 || in_tc1 || in_ig;

  assign misalign = ((st_type == ST_W) && (addr[1:0] != 2'b00)) ||
                    ((st_type == ST_H) && addr[0]);

  // COUNT registers are read-only from the store path
  assign count_wr = (st_type == ST_W) &&
                    ((addr == TC0_BASE + TC_COUNT) || (addr == TC1_BASE + TC_COUNT));

  assign ades = misalign || !(in_dm || in_dev) ||
                ((st_type != ST_W) && in_dev) || count_wr;

endmodule

// File: rtl/store_aligner.sv
// P7 M-stage store aligner: lane/byte-enable narrowing, AdES detection and a
// valid/ready write request to the bridge, stalling the pipeline while pending.
module store_aligner
  import store_aligner_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  input  logic        mem_ready,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byteen,
  output logic        stall,
  output logic        exc_ades,
  output logic        done
);

  state_t      state, state_nxt;
  logic        m_valid_nxt, exc_nxt, done_nxt;
  logic [31:0] m_addr_nxt, m_wdata_nxt;
  logic [3:0]  m_byteen_nxt;
  logic        ades, accept;
  logic [31:0] lane_data;
  logic [3:0]  lane_be;

  store_addr_check u_check (
    .addr    (addr),
    .st_type (req_type),
    .ades    (ades)
  );

  assign accept = (state == IDLE) && req_valid && !flush && (req_type != ST_NOP);

  always_comb begin
    lane_data = wdata;
    lane_be   = 4'b1111;
    case (req_type)
      ST_H: begin
        lane_data = {wdata[15:0], wdata[15:0]};
        lane_be   = addr[1] ? 4'b1100 : 4'b0011;
      end
      ST_B: begin
        lane_data = {4{wdata[7:0]}};
        lane_be   = 4'b0001 << addr[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    m_valid_nxt  = m_valid;
    m_addr_nxt   = m_addr;
    m_wdata_nxt  = m_wdata;
    m_byteen_nxt = m_byteen;
    exc_nxt      = 1'b0;
    done_nxt     = 1'b0;
    stall        = 1'b0;
    case (state)
      IDLE: begin
        if (accept && ades) begin
          exc_nxt = 1'b1;
        end else if (accept) begin
          stall        = 1'b1;
          m_valid_nxt  = 1'b1;
          m_addr_nxt   = {addr[31:2], 2'b00};
          m_wdata_nxt  = lane_data;
          m_byteen_nxt = lane_be;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        // an accepted write wins over a same-cycle flush
        if (mem_ready) begin
          done_nxt    = 1'b1;
          m_valid_nxt = 1'b0;
          state_nxt   = IDLE;
        end else if (flush) begin
          m_valid_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_byteen <= '0;
      exc_ades <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      m_valid  <= m_valid_nxt;
      m_addr   <= m_addr_nxt;
      m_wdata  <= m_wdata_nxt;
      m_byteen <= m_byteen_nxt;
      exc_ades <= exc_nxt;
      done     <= done_nxt;
    end
  end

endmodule
